scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder.sv | 181 ++++++++++++++++++
 tb/tb_scan_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// Scanning one-hot decoder.
// Drives a registered one-hot decode of an index that is either taken directly from
// din or scanned up, down or ping-pong, advancing one step every dwell+1 enabled
// cycles. wrap pulses for one cycle on a wrap-around or a ping-pong reversal.
module scan_decoder #(
    parameter int unsigned IN_W    = 4,
    parameter int unsigned DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [IN_W-1:0]      din,
    input  logic                 load,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [2**IN_W-1:0]   dout,
    output logic [IN_W-1:0]      idx,
    output logic                 wrap
);

    localparam int unsigned OutW = 2 ** IN_W;

    localparam logic [IN_W-1:0]    IdxMax   = '1;
    localparam logic [IN_W-1:0]    IdxMin   = '0;
    localparam logic [IN_W-1:0]    IdxOne   = IN_W'(1);
    localparam logic [DWELL_W-1:0] CntOne   = DWELL_W'(1);

    typedef enum logic [1:0] {
        ModeDirect   = 2'b00,
        ModeUp       = 2'b01,
        ModeDown     = 2'b10,
        ModePingpong = 2'b11
    } mode_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    // State registers
    logic [IN_W-1:0]    idx_q, idx_d;
    logic [OutW-1:0]    dout_q, dout_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    dir_e               dir_q, dir_d;
    logic [1:0]         mode_q, mode_d;
    // Set by the first load or enabled cycle after reset; until then dout is all zeros
    // and the mode history is meaningless.
    logic               primed_q, primed_d;

    // Step evaluation
    mode_e              mode_cur;
    logic               mode_changed;
    logic               step_due;
    logic [IN_W-1:0]    step_idx;
    dir_e               step_dir;
    logic               step_wrap;

    assign mode_cur = mode_e'(mode);

    function automatic logic [OutW-1:0] onehot(input logic [IN_W-1:0] v);
        logic [OutW-1:0] r;
        r    = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    // Decide whether this cycle steps; a mode-change cycle restarts the dwell period.
    always_comb begin
        mode_changed = primed_q && (mode != mode_q);
        step_due     = primed_q && !mode_changed && (cnt_q >= dwell);
    end

    // Compute the index, direction and wrap flag a step would produce in the current mode.
    always_comb begin
        step_idx  = idx_q;
        step_dir  = dir_q;
        step_wrap = 1'b0;
        unique case (mode_cur)
            ModeUp: begin
                step_idx  = idx_q + IdxOne;
                step_wrap = (idx_q == IdxMax);
            end
            ModeDown: begin
                step_idx  = idx_q - IdxOne;
                step_wrap = (idx_q == IdxMin);
            end
            ModePingpong: begin
                if (dir_q == DirUp) begin
                    if (idx_q == IdxMax) begin
                        step_idx  = IdxMax - IdxOne;
                        step_dir  = DirDown;
                        step_wrap = 1'b1;
                    end else begin
                        step_idx  = idx_q + IdxOne;
                    end
                end else begin
                    if (idx_q == IdxMin) begin
                        step_idx  = IdxMin + IdxOne;
                        step_dir  = DirUp;
                        step_wrap = 1'b1;
                    end else begin
                        step_idx  = idx_q - IdxOne;
                    end
                end
            end
            default: begin
                // DIRECT never steps; the index comes straight from din.
            end
        endcase
    end

    // Next-state selection: load beats enable, enable low freezes everything.
    always_comb begin
        idx_d    = idx_q;
        dout_d   = dout_q;
        wrap_d   = 1'b0;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        primed_d = primed_q;

        if (load) begin
            idx_d    = din;
            dout_d   = onehot(din);
            cnt_d    = '0;
            mode_d   = mode;
            primed_d = 1'b1;
        end else if (en) begin
            mode_d   = mode;
            primed_d = 1'b1;
            if (mode_cur == ModeDirect) begin
                idx_d  = din;
                dout_d = onehot(din);
                cnt_d  = '0;
            end else if (step_due) begin
                idx_d  = step_idx;
                dout_d = onehot(step_idx);
                dir_d  = step_dir;
                wrap_d = step_wrap;
                cnt_d  = '0;
            end else if (mode_changed) begin
                dout_d = onehot(idx_q);
                cnt_d  = '0;
            end else begin
                // cnt_q < dwell here, so the increment cannot overflow.
                dout_d = onehot(idx_q);
                cnt_d  = cnt_q + CntOne;
            end
        end
    end

    // State register with asynchronous reset that aborts any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            dout_q   <= '0;
            wrap_q   <= 1'b0;
            cnt_q    <= '0;
            dir_q    <= DirUp;
            mode_q   <= ModeDirect;
            primed_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            dout_q   <= dout_d;
            wrap_q   <= wrap_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            primed_q <= primed_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        dout = dout_q;
        idx  = idx_q;
        wrap = wrap_q;
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed testbench for scan_decoder (IN_W=4, DWELL_W=8).
module tb_scan_decoder;

    localparam logic [1:0] MD = 2'b00;
    localparam logic [1:0] MU = 2'b01;
    localparam logic [1:0] MN = 2'b10;
    localparam logic [1:0] MP = 2'b11;

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic       load;
        logic [1:0] mode;
        logic [3:0] din;
        logic [7:0] dwell;
        logic [3:0] e_idx;
        logic       e_dz;
        logic       e_wrap;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [1:0]  mode = MD;
    logic [3:0]  din = '0;
    logic [7:0]  dwell = '0;
    logic [15:0] dout;
    logic [3:0]  idx;
    logic        wrap;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    scan_decoder #(
        .IN_W   (4),
        .DWELL_W(8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .din  (din),
        .load (load),
        .dwell(dwell),
        .dout (dout),
        .idx  (idx),
        .wrap (wrap)
    );

    task automatic add(input string name, input logic r, input logic e, input logic l,
                       input logic [1:0] m, input logic [3:0] d, input logic [7:0] dw,
                       input logic [3:0] ei, input logic edz, input logic ew);
        vec_t v;
        v.name = name; v.rst = r; v.en = e; v.load = l; v.mode = m; v.din = d;
        v.dwell = dw; v.e_idx = ei; v.e_dz = edz; v.e_wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [3:0] e_idx, input logic e_dz,
                               input logic e_wrap);
        logic [15:0] e_dout;
        e_dout = e_dz ? 16'h0000 : (16'h0001 << e_idx);
        check({name, " idx"}, {12'h000, idx}, {12'h000, e_idx});
        check({name, " dout"}, dout, e_dout);
        check({name, " wrap"}, {15'h0000, wrap}, {15'h0000, e_wrap});
    endtask

    task automatic drive(input logic r, input logic e, input logic l, input logic [1:0] m,
                         input logic [3:0] d, input logic [7:0] dw);
        @(negedge clk);
        rst = r; en = e; load = l; mode = m; din = d; dwell = dw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] dseq [9];
        logic       dwr  [9];
        dseq = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd15, 4'd14};
        dwr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset and DIRECT decode
        add("reset", 1, 0, 0, MD, 0, 0, 0, 1, 0);
        add("direct din9", 0, 1, 0, MD, 9, 0, 9, 0, 0);
        add("reset again", 1, 0, 0, MU, 0, 0, 0, 1, 0);
        // UP, dwell 0: first enabled cycle only refreshes dout, then steps every cycle
        add("up first", 0, 1, 0, MU, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) add($sformatf("up step%0d", i), 0, 1, 0, MU, 0, 0,
                                          4'(i), 0, (i == 16));
        add("up en low after wrap", 0, 0, 0, MU, 0, 0, 0, 0, 0);
        add("up after wrap", 0, 1, 0, MU, 0, 0, 1, 0, 0);
        add("load with en low", 0, 0, 1, MU, 5, 0, 5, 0, 0);
        // DOWN, dwell 2, from load 1
        add("down load1", 0, 0, 1, MN, 1, 2, 1, 0, 0);
        for (int i = 0; i < 9; i++) add($sformatf("down c%0d", i), 0, 1, 0, MN, 0, 2,
                                        dseq[i], 0, dwr[i]);
        // PINGPONG, dwell 0
        add("pp load14", 0, 0, 1, MP, 14, 0, 14, 0, 0);
        add("pp 15", 0, 1, 0, MP, 0, 0, 15, 0, 0);
        add("pp rev 14", 0, 1, 0, MP, 0, 0, 14, 0, 1);
        add("pp 13", 0, 1, 0, MP, 0, 0, 13, 0, 0);
        add("pp load1", 0, 1, 1, MP, 1, 0, 1, 0, 0);
        add("pp 0", 0, 1, 0, MP, 0, 0, 0, 0, 0);
        add("pp rev 1", 0, 1, 0, MP, 0, 0, 1, 0, 1);
        add("pp 2", 0, 1, 0, MP, 0, 0, 2, 0, 0);
        // Mode change clears the dwell count
        add("mc load5", 0, 0, 1, MU, 5, 2, 5, 0, 0);
        add("mc up c1", 0, 1, 0, MU, 0, 2, 5, 0, 0);
        add("mc up c2", 0, 1, 0, MU, 0, 2, 5, 0, 0);
        add("mc switch down", 0, 1, 0, MN, 0, 2, 5, 0, 0);
        add("mc down c1", 0, 1, 0, MN, 0, 2, 5, 0, 0);
        add("mc down c2", 0, 1, 0, MN, 0, 2, 5, 0, 0);
        add("mc down step", 0, 1, 0, MN, 0, 2, 4, 0, 0);
        // Lowering dwell below the count steps at once
        add("dl load0", 0, 0, 1, MU, 0, 5, 0, 0, 0);
        add("dl c1", 0, 1, 0, MU, 0, 5, 0, 0, 0);
        add("dl c2", 0, 1, 0, MU, 0, 5, 0, 0, 0);
        add("dl c3", 0, 1, 0, MU, 0, 5, 0, 0, 0);
        add("dl lowered", 0, 1, 0, MU, 0, 1, 1, 0, 0);
        add("dl c5", 0, 1, 0, MU, 0, 1, 1, 0, 0);
        add("dl c6", 0, 1, 0, MU, 0, 1, 2, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].mode, vecs[i].din,
                  vecs[i].dwell);
            check_state(vecs[i].name, vecs[i].e_idx, vecs[i].e_dz, vecs[i].e_wrap);
        end

        // en low mid-dwell freezes the count; the step resumes with the remainder
        drive(0, 0, 1, MU, 3, 3);
        check_state("fz load3", 3, 0, 0);
        drive(0, 1, 0, MU, 0, 3);
        check_state("fz c1", 3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, MU, 0, 3);
            check_state($sformatf("fz hold%0d", i), 3, 0, 0);
        end
        drive(0, 1, 0, MU, 0, 3);
        check_state("fz c2", 3, 0, 0);
        drive(0, 1, 0, MU, 0, 3);
        check_state("fz c3", 3, 0, 0);
        drive(0, 1, 0, MU, 0, 3);
        check_state("fz step", 4, 0, 0);

        // Asynchronous reset between edges during an UP scan at idx 7
        drive(0, 0, 1, MU, 7, 10);
        drive(0, 1, 0, MU, 0, 10);
        check_state("ar before", 7, 0, 0);
        @(negedge clk);
        en = 1'b0;
        #2 rst = 1'b1;
        #1 check_state("ar async", 0, 1, 0);
        #1 rst = 1'b0;
        // Restart from 0 with a full dwell period before the first step
        drive(0, 1, 0, MU, 0, 1);
        check_state("ar restart c1", 0, 0, 0);
        drive(0, 1, 0, MU, 0, 1);
        check_state("ar restart step", 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
